// File: rtl/spi_rx_if.sv
// Word-stream and status bundle between spi_rx and its fabric consumer.
interface spi_rx_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [2:0]       rx_level;
    logic             rx_overrun;
    logic             frame_err;
    logic             ss_active;

    modport master (
        output rx_data, rx_valid, rx_level, rx_overrun, frame_err, ss_active,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_level, rx_overrun, frame_err, ss_active,
        output rx_ready
    );
endinterface

// File: rtl/spi_rx.sv
// Oversampling SPI receiver: MSB-first words from SCK/SS/MOSI into a ready/valid buffer.
// Define SPI_RX_FIFO_EN for a 4-entry FIFO; otherwise a single holding register is used.
module spi_rx #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          SAMPLE_RISE = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     spi_sck,
    input  logic     spi_ss_n,
    input  logic     spi_mosi,
    spi_rx_if.master rx
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                   sck_hist_q, ss_hist_q, mosi_dly_q;
    logic                   sck_s, ss_s;
    logic                   sample_c, ss_fall_c, ss_rise_c;

    state_t                 state_q, state_d;
    logic                   active_c;

    logic [CNT_W-1:0]       bit_cnt_q;
    logic [WIDTH-1:0]       shift_q, shift_nxt_c;
    logic                   push_q;
    logic [WIDTH-1:0]       push_word_q;
    logic                   frame_err_q;

    logic [WIDTH-1:0]       rx_data_q, head_d;
    logic                   rx_valid_q;
    logic [2:0]             level_q, level_d;
    logic                   overrun_q;
    logic                   pop_c, accept_c;

    // Input synchronizers plus one history flop; MOSI delayed to line up with SCK history
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_hist_q  <= 1'b0;
            ss_hist_q   <= 1'b0;
            mosi_dly_q  <= 1'b0;
        end else begin
            sck_sync_q  <= SYNC_STAGES'({sck_sync_q, spi_sck});
            ss_sync_q   <= SYNC_STAGES'({ss_sync_q, spi_ss_n});
            mosi_sync_q <= SYNC_STAGES'({mosi_sync_q, spi_mosi});
            sck_hist_q  <= sck_sync_q[SYNC_STAGES-1];
            ss_hist_q   <= ss_sync_q[SYNC_STAGES-1];
            mosi_dly_q  <= mosi_sync_q[SYNC_STAGES-1];
        end
    end

    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sample_c  = SAMPLE_RISE ? (sck_s & ~sck_hist_q) : (~sck_s & sck_hist_q);
    assign ss_fall_c = ~ss_s & ss_hist_q;
    assign ss_rise_c = ss_s & ~ss_hist_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_DISARMED;
        else     state_q <= state_d;
    end

    // Stay disarmed until SS is seen high, so a reset inside a frame never starts mid-word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: if (ss_s)      state_d = ST_IDLE;
            ST_IDLE:     if (ss_fall_c) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (ss_rise_c) state_d = ST_IDLE;
            default:                    state_d = ST_DISARMED;
        endcase
    end

    always_comb begin
        active_c = 1'b0;
        if (state_q == ST_ACTIVE) active_c = 1'b1;
    end

    assign shift_nxt_c = WIDTH'({shift_q, mosi_dly_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            push_word_q <= '0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            if ((state_q == ST_IDLE) && ss_fall_c) begin
                bit_cnt_q <= '0;
                shift_q   <= '0;
            end else if (state_q == ST_ACTIVE) begin
                if (ss_rise_c) begin
                    bit_cnt_q   <= '0;
                    frame_err_q <= (bit_cnt_q != '0);
                end else if (sample_c) begin
                    shift_q <= shift_nxt_c;
                    if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                        bit_cnt_q   <= '0;
                        push_q      <= 1'b1;
                        push_word_q <= shift_nxt_c;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign pop_c = rx_valid_q & rx.rx_ready;

`ifdef SPI_RX_FIFO_EN
    logic [WIDTH-1:0] mem_q [4];
    logic [1:0]       wr_ptr_q, rd_ptr_q, rd_next_c;

    // Head is re-registered each cycle; a write into an empty slot becomes the head directly
    always_comb begin
        rd_next_c = rd_ptr_q + 2'(pop_c);
        accept_c  = push_q & ((level_q != 3'd4) | pop_c);
        level_d   = level_q + 3'(accept_c) - 3'(pop_c);
        head_d    = mem_q[rd_next_c];
        if (accept_c && (wr_ptr_q == rd_next_c)) head_d = push_word_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (accept_c) wr_ptr_q <= wr_ptr_q + 2'd1;
            rd_ptr_q <= rd_next_c;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_c) mem_q[wr_ptr_q] <= push_word_q;
    end
`else
    always_comb begin
        accept_c = push_q & (~rx_valid_q | pop_c);
        head_d   = rx_data_q;
        if (accept_c) head_d = push_word_q;
        level_d  = {2'b00, accept_c | (rx_valid_q & ~pop_c)};
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            rx_data_q  <= head_d;
            rx_valid_q <= (level_d != 3'd0);
            level_q    <= level_d;
            if (push_q && !accept_c) overrun_q <= 1'b1;
        end
    end

    assign rx.rx_data    = rx_data_q;
    assign rx.rx_valid   = rx_valid_q;
    assign rx.rx_level   = level_q;
    assign rx.rx_overrun = overrun_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.ss_active  = active_c;
endmodule
